// File: rtl/ibuf_sync_filt.sv
// Purpose: synchronize a shared tri-state pad level and glitch-filter it while the local driver is released.
// Latency: SYNC_STAGES flops plus FILTER_LEN agreeing samples; O changes k+1+FILTER_LEN edges after I settles (SYNC_STAGES=2).
// Backpressure: none; free-running sampler, VALID marks when O tracks the line (state LISTEN).
module ibuf_sync_filt #(
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int FILTER_LEN  = 4,   // 1..255
  parameter int TURN_CYCLES = 3    // 1..255
) (
  input  logic C,
  input  logic R,
  input  logic I,
  input  logic T,
  output logic O,
  output logic RISE,
  output logic FALL,
  output logic VALID
);

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    TURN   = 2'd1,
    LISTEN = 2'd2
  } state_t;

  localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);
  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [7:0]             turn_cnt_q, turn_cnt_d;
  logic [7:0]             filt_cnt_q, filt_cnt_d;
  logic                   o_q, o_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Plain shift chain: no logic between stages, keeps sampling in every state.
  always_ff @(posedge C) begin
    if (R) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State, counters, filtered level and edge pulses.
  always_ff @(posedge C) begin
    if (R) begin
      state_q    <= DRIVE;
      turn_cnt_q <= '0;
      filt_cnt_q <= '0;
      o_q        <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      filt_cnt_q <= filt_cnt_d;
      o_q        <= o_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  // Next state: T=0 always wins, so a filter that would fire this cycle is suppressed.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    filt_cnt_d = '0;
    o_d        = o_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    case (state_q)
      DRIVE: begin
        turn_cnt_d = '0;
        if (T) begin
          state_d = TURN;
        end
      end
      TURN: begin
        if (!T) begin
          state_d    = DRIVE;
          turn_cnt_d = '0;
        end else if (turn_cnt_q == TURN_LAST) begin
          state_d    = LISTEN;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 8'd1;
        end
      end
      LISTEN: begin
        if (!T) begin
          state_d = DRIVE;
        end else if (s != o_q) begin
          if (filt_cnt_q == FILT_LAST) begin
            o_d    = s;
            rise_d = s;
            fall_d = ~s;
          end else begin
            filt_cnt_d = filt_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d    = DRIVE;
        turn_cnt_d = '0;
      end
    endcase
  end

  assign O     = o_q;
  assign RISE  = rise_q;
  assign FALL  = fall_q;
  assign VALID = (state_q == LISTEN);

endmodule

// File: tb/tb_ibuf_sync_filt.sv
module tb_ibuf_sync_filt;

  localparam int TC = 3;
  localparam int FL = 4;

  logic C = 1'b0;
  logic R = 1'b1;
  logic I = 1'b1;
  logic T = 1'b1;
  logic O, RISE, FALL, VALID;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural reference: two-flop history, mode 0=drive 1=turn 2=listen.
  logic m_i1 = 1'b0, m_i2 = 1'b0;
  int   m_mode = 0, m_tc = 0, m_fc = 0;
  logic m_o = 1'b0, m_rise = 1'b0, m_fall = 1'b0;

  ibuf_sync_filt #(.SYNC_STAGES(2), .FILTER_LEN(FL), .TURN_CYCLES(TC)) dut (
    .C(C), .R(R), .I(I), .T(T), .O(O), .RISE(RISE), .FALL(FALL), .VALID(VALID)
  );

  always #5 C = ~C;

  task automatic model_update();
    logic ms;
    if (R) begin
      m_i1 = 0; m_i2 = 0; m_mode = 0; m_tc = 0; m_fc = 0;
      m_o = 0; m_rise = 0; m_fall = 0;
    end else begin
      ms = m_i2; m_i2 = m_i1; m_i1 = I;
      m_rise = 0; m_fall = 0;
      if (!T) begin
        m_mode = 0; m_tc = 0; m_fc = 0;
      end else begin
        case (m_mode)
          0: begin m_mode = 1; m_tc = 0; end
          1: if (m_tc == TC - 1) m_mode = 2; else m_tc = m_tc + 1;
          default: begin
            if (ms == m_o) m_fc = 0;
            else if (m_fc == FL - 1) begin
              m_o = ms; m_rise = ms; m_fall = !ms; m_fc = 0;
            end else m_fc = m_fc + 1;
          end
        endcase
      end
    end
  endtask

  // One clock edge; reference advances with the inputs the DUT samples.
  task automatic tick();
    model_update();
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {O,RISE,FALL,VALID}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic r, input logic t, input logic i,
                     input logic [3:0] exp);
    R = r; T = t; I = i;
    tick();
    chk(tag, {O, RISE, FALL, VALID}, exp);
  endtask

  initial begin
    // Reset dominates T=1, I=1
    run("rst0", 1, 1, 1, 4'b0000);
    run("rst1", 1, 1, 1, 4'b0000);

    // Turnaround then rising filter: VALID at E4, O/RISE at E8
    run("e1_turn", 0, 1, 1, 4'b0000);
    run("e2_turn", 0, 1, 1, 4'b0000);
    run("e3_turn", 0, 1, 1, 4'b0000);
    run("e4_valid", 0, 1, 1, 4'b0001);
    run("e5_filt", 0, 1, 1, 4'b0001);
    run("e6_filt", 0, 1, 1, 4'b0001);
    run("e7_filt", 0, 1, 1, 4'b0001);
    run("e8_rise", 0, 1, 1, 4'b1101);
    run("e9_high", 0, 1, 1, 4'b1001);

    // 3-cycle low glitch: O holds, no FALL
    run("g3_a", 0, 1, 0, 4'b1001);
    run("g3_b", 0, 1, 0, 4'b1001);
    run("g3_c", 0, 1, 0, 4'b1001);
    run("g3_d", 0, 1, 1, 4'b1001);
    run("g3_e", 0, 1, 1, 4'b1001);
    run("g3_f", 0, 1, 1, 4'b1001);

    // 4-cycle low pulse: exactly FILTER_LEN, fires FALL, then recovers
    run("g4_a", 0, 1, 0, 4'b1001);
    run("g4_b", 0, 1, 0, 4'b1001);
    run("g4_c", 0, 1, 0, 4'b1001);
    run("g4_d", 0, 1, 0, 4'b1001);
    run("g4_e", 0, 1, 1, 4'b1001);
    run("g4_fall", 0, 1, 1, 4'b0011);
    run("g4_g", 0, 1, 1, 4'b0001);
    run("g4_h", 0, 1, 1, 4'b0001);
    run("g4_i", 0, 1, 1, 4'b0001);
    run("g4_rise", 0, 1, 1, 4'b1101);
    run("g4_k", 0, 1, 1, 4'b1001);

    // Reset while O=1 in LISTEN: O drops with no FALL
    run("rst_mid", 1, 1, 1, 4'b0000);
    run("post_rst_a", 0, 1, 1, 4'b0000);
    run("post_rst_b", 0, 1, 1, 4'b0000);
    run("post_rst_c", 0, 1, 1, 4'b0000);
    run("post_rst_listen", 0, 1, 1, 4'b0001);

    // T falls on the edge the filter would fire: no change, no RISE
    run("pri_a", 0, 1, 1, 4'b0001);
    run("pri_b", 0, 1, 1, 4'b0001);
    run("pri_c", 0, 1, 1, 4'b0001);
    run("pri_tfall", 0, 0, 1, 4'b0000);
    run("pri_drive", 0, 0, 1, 4'b0000);

    // T = 1,1,0,1,1,1: LISTEN only after three TURN cycles past the last 0
    run("tog_1", 0, 1, 1, 4'b0000);
    run("tog_2", 0, 1, 1, 4'b0000);
    run("tog_3", 0, 0, 1, 4'b0000);
    run("tog_4", 0, 1, 1, 4'b0000);
    run("tog_5", 0, 1, 1, 4'b0000);
    run("tog_6", 0, 1, 1, 4'b0000);
    run("tog_listen", 0, 1, 1, 4'b0001);
    run("tog_f1", 0, 1, 1, 4'b0001);
    run("tog_f2", 0, 1, 1, 4'b0001);
    run("tog_f3", 0, 1, 1, 4'b0001);
    run("tog_rise", 0, 1, 1, 4'b1101);

    // Random I/T/R against the reference model
    for (int k = 0; k < 10000; k++) begin
      R = ($urandom_range(0, 255) == 0);
      T = ($urandom_range(0, 23) != 0);
      if ($urandom_range(0, 3) == 0) I = ~I;
      tick();
      chk("rand", {O, RISE, FALL, VALID}, {m_o, m_rise, m_fall, (m_mode == 2) ? 1'b1 : 1'b0});
      chk("rise_fall_excl", {3'b000, RISE & FALL}, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ibuf_sync_filt.md
IBUF_SYNC_FILT -- requirements
Module: ibuf_sync_filt

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on I (legal 2..4).
REQ-002 The block SHALL have parameter FILTER_LEN, default 4, meaning the consecutive agreeing samples needed before O changes (legal 1..255).
REQ-003 The block SHALL have parameter TURN_CYCLES, default 3, meaning the blanking cycles after the local driver releases the line (legal 1..255).
REQ-004 C  input  1  the single clock; all state SHALL update on the rising edge of C.
REQ-005 R  input  1  reset, synchronous, active-high.
REQ-006 I  input  1  pad level from a shared tri-state line; asynchronous to C.
REQ-007 T  input  1  local tri-state control, synchronous to C; 1 = local driver off (receive), 0 = local driver on.
REQ-008 O  output  1  filtered, synchronized line level.
REQ-009 RISE  output  1  one-cycle pulse on each 0->1 change of O.
REQ-010 FALL  output  1  one-cycle pulse on each 1->0 change of O.
REQ-011 VALID  output  1  high while in state LISTEN.

Function
REQ-012 I SHALL pass through SYNC_STAGES flops; s denotes the last stage; no logic SHALL be placed between stages.
REQ-013 The state machine SHALL have three states: DRIVE, TURN and LISTEN.
REQ-014 DRIVE transitions: T=1 -> TURN, with the turnaround counter loaded to 0; T=0 -> remain in DRIVE.
REQ-015 TURN transitions: T=0 -> DRIVE; otherwise the counter increments, and when it equals TURN_CYCLES-1 the next state is LISTEN.
REQ-016 LISTEN transitions: T=0 -> DRIVE; otherwise remain in LISTEN.
REQ-017 In DRIVE and TURN, O SHALL hold its value, the filter counter SHALL be 0, and RISE and FALL SHALL be 0.
REQ-018 In LISTEN with s==O, the filter counter SHALL clear to 0.
REQ-019 In LISTEN with s!=O and filter counter == FILTER_LEN-1, the block SHALL set O<=s and clear the counter.
REQ-020 In LISTEN with s!=O and filter counter < FILTER_LEN-1, the filter counter SHALL increment.
REQ-021 The filter counter SHALL be 8 bits and SHALL never wrap, because it clears at FILTER_LEN-1.
REQ-022 RISE and FALL SHALL be registered, asserted on the same edge O changes, and never high together.
REQ-023 Latency: I stable from sampling edge k, in LISTEN, with SYNC_STAGES=2, SHALL change O at edge k+1+FILTER_LEN.
REQ-024 A pulse on s shorter than FILTER_LEN cycles SHALL never change O.
REQ-025 T falling in the same cycle that the filter would fire SHALL take priority: state goes to DRIVE, O is unchanged, and no pulse is produced.
REQ-026 The synchronizer SHALL keep sampling in all states, so s is current when LISTEN is entered.
REQ-027 The filter SHALL start from count 0 on LISTEN entry.

Reset
REQ-028 With R=1 at an edge, the block SHALL force state=DRIVE, O=0, RISE=0, FALL=0, VALID=0, both counters=0, and all synchronizer flops=0.
REQ-029 R SHALL take priority over every other input.
REQ-030 R asserted mid-TURN or mid-filter SHALL discard the count.
REQ-031 After R falls, the first state evaluation SHALL use T at the next edge.

Verification
REQ-032 Reset, then T=1, I=1 held: VALID rises 3 edges after T is first sampled high; O=1 at edge 3+1+4 from the first I sample; RISE=1 for exactly that cycle.
REQ-033 In LISTEN with O=1, I=0 for 3 cycles then back to 1: O stays 1 and FALL stays 0.
REQ-034 In LISTEN with O=0, I=1 stable, T driven 0 on the edge where the counter is 3: O stays 0, VALID=0 the next cycle, and no RISE.
REQ-035 T toggled 1,1,0,1,1,1 with TURN_CYCLES=3: the block never reaches LISTEN until 3 consecutive T=1 cycles after the last 0.
REQ-036 R pulsed for 1 cycle while O=1 in LISTEN: next cycle O=0, VALID=0, no FALL pulse.
REQ-037 Random I/T sequence of 10k cycles versus a reference model: O, RISE, FALL and VALID match cycle-exactly, with RISE&FALL never both 1.
